// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single SRAM controller request port among the
// bootloader (write-only), instruction fetch (read-only) and data port
// (read/write). While boot_mode is high, only the bootloader is eligible.
// Otherwise instruction and data ports alternate when both request. A
// watchdog on the BUSY phase aborts hung transactions and flags ack_err.
// Every output is driven straight from a flop.
module sram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_mode,
  // bootloader write port
  input  logic                  boot_req,
  input  logic [ADDR_WIDTH-1:0] boot_addr,
  input  logic [DATA_WIDTH-1:0] boot_wdata,
  output logic                  boot_ack,
  // instruction fetch port
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_ack,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  // processor data port
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  ack_err,
  // SRAM controller side
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PORT_BOOT = 2'd0,
    PORT_INST = 2'd1,
    PORT_DATA = 2'd2
  } port_e;

  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Current state
  state_e                state_q;
  port_e                 owner_q;
  port_e                 last_grant_q;
  logic [CNT_W-1:0]      cnt_q;

  // Next state
  state_e                state_d;
  port_e                 owner_d;
  port_e                 last_grant_d;
  logic [CNT_W-1:0]      cnt_d;
  logic                  mem_req_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  boot_ack_d;
  logic                  inst_ack_d;
  logic                  data_ack_d;
  logic                  ack_err_d;
  logic [DATA_WIDTH-1:0] inst_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_d;
  logic                  busy_d;

  // Arbitration result for the current IDLE cycle
  logic                  grant;
  port_e                 grant_port;

  // Completion helpers for the BUSY phase
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] resp_data;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Choose which requester would win if the FSM is in IDLE this cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant      = 1'b0;
    grant_port = PORT_BOOT;
    if (boot_mode) begin
      // Boot owns the memory; inst and data requests wait indefinitely.
      if (boot_req) begin
        grant      = 1'b1;
        grant_port = PORT_BOOT;
      end
    end else if (inst_req && data_req) begin
      // Tie: the port that did not win last time gets the grant.
      grant      = 1'b1;
      grant_port = (last_grant_q == PORT_INST) ? PORT_DATA : PORT_INST;
    end else if (inst_req) begin
      grant      = 1'b1;
      grant_port = PORT_INST;
    end else if (data_req) begin
      grant      = 1'b1;
      grant_port = PORT_DATA;
    end
  end

  // Next-state and next-output logic for the IDLE -> BUSY -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    boot_ack_d   = 1'b0;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    ack_err_d    = 1'b0;
    inst_rdata_d = inst_rdata;
    data_rdata_d = data_rdata;
    resp_data    = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          // Latch the winner's payload; later changes on its inputs are ignored.
          state_d   = ST_BUSY;
          owner_d   = grant_port;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          case (grant_port)
            PORT_BOOT: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = boot_addr;
              mem_wdata_d = boot_wdata;
            end
            PORT_INST: begin
              mem_we_d     = 1'b0;
              mem_addr_d   = inst_addr;
              last_grant_d = PORT_INST;
            end
            default: begin
              mem_we_d     = data_we;
              mem_addr_d   = data_addr;
              mem_wdata_d  = data_wdata;
              last_grant_d = PORT_DATA;
            end
          endcase
        end
      end

      ST_BUSY: begin
        if (mem_ack || timeout_hit) begin
          // A real completion wins over a timeout in the same cycle.
          state_d   = ST_RESP;
          ack_err_d = !mem_ack;
          resp_data = mem_ack ? mem_rdata : '0;
          case (owner_q)
            PORT_BOOT: boot_ack_d = 1'b1;
            PORT_INST: begin
              inst_ack_d   = 1'b1;
              inst_rdata_d = resp_data;
            end
            default: begin
              data_ack_d   = 1'b1;
              data_rdata_d = resp_data;
            end
          endcase
        end else begin
          mem_req_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        // The ack pulse lives in this cycle only; drop back to arbitration.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the payload and read-data registers are reset as well, because
      // their values are visible on the ports straight after reset.
      state_q      <= ST_IDLE;
      owner_q      <= PORT_BOOT;
      last_grant_q <= PORT_DATA;
      cnt_q        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      boot_ack     <= 1'b0;
      inst_ack     <= 1'b0;
      data_ack     <= 1'b0;
      ack_err      <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      boot_ack     <= boot_ack_d;
      inst_ack     <= inst_ack_d;
      data_ack     <= data_ack_d;
      ack_err      <= ack_err_d;
      inst_rdata   <= inst_rdata_d;
      data_rdata   <= data_rdata_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a transaction-level model predicts the
// grant order and responses, a responder emulates the SRAM controller, and a
// monitor compares every ack against the scoreboard.
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int DW         = 32;
  localparam int AW         = 20;
  localparam int TB_TIMEOUT = 4;
  localparam int P_BOOT     = 0;
  localparam int P_INST     = 1;
  localparam int P_DATA     = 2;

  typedef struct {
    int          port;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int          delay;   // mem_req cycle in which mem_ack is given; > TB_TIMEOUT means never
  } plan_t;

  typedef struct {
    int          port;
    logic        err;
    logic [DW-1:0] inst_rd;
    logic [DW-1:0] data_rd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot_mode;
  logic          boot_req;
  logic [AW-1:0] boot_addr;
  logic [DW-1:0] boot_wdata;
  logic          boot_ack;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_ack;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_ack;
  logic [DW-1:0] data_rdata;
  logic          ack_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy;

  sram_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .boot_mode (boot_mode),
    .boot_req  (boot_req),
    .boot_addr (boot_addr),
    .boot_wdata(boot_wdata),
    .boot_ack  (boot_ack),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_ack  (inst_ack),
    .inst_rdata(inst_rdata),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_ack  (data_ack),
    .data_rdata(data_rdata),
    .ack_err   (ack_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  // Reference model state
  int            m_last;
  logic [DW-1:0] m_inst_rd;
  logic [DW-1:0] m_data_rd;
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] rmem      [logic [AW-1:0]];

  // Per-port, per-transaction payloads for the current round
  logic [AW-1:0] pa  [3][4];
  logic [DW-1:0] pd  [3][4];
  logic          pw  [3][4];
  int            pdl [3][4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {12'hC0D, a};
  endfunction

  task automatic gen_payloads();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        pa[p][k]  = AW'($urandom_range(0, 15));
        pd[p][k]  = $urandom;
        pw[p][k]  = 1'($urandom_range(0, 1));
        pdl[p][k] = $urandom_range(1, TB_TIMEOUT + 1);
      end
    end
  endtask

  task automatic apply(input int p, input int k);
    case (p)
      P_BOOT: begin
        boot_addr  = pa[0][k];
        boot_wdata = pd[0][k];
      end
      P_INST: inst_addr = pa[1][k];
      default: begin
        data_addr  = pa[2][k];
        data_wdata = pd[2][k];
        data_we    = pw[2][k];
      end
    endcase
  endtask

  // Garbage on a port whose payload has already been sampled.
  task automatic scramble(input int p);
    case (p)
      P_BOOT: begin
        boot_addr  = AW'($urandom);
        boot_wdata = $urandom;
      end
      P_INST: inst_addr = AW'($urandom);
      default: begin
        data_addr  = AW'($urandom);
        data_wdata = $urandom;
        data_we    = 1'($urandom_range(0, 1));
      end
    endcase
  endtask

  task automatic model_reset();
    m_last    = P_DATA;
    m_inst_rd = '0;
    m_data_rd = '0;
    exp_q.delete();
    plan_q.delete();
  endtask

  // One round: each port asks for nb/ni/nd transactions, re-presenting its
  // request after every ack until its count is used up.
  task automatic run_round(input logic bm, input int nb, input int ni, input int nd);
    int cnt[3];
    int eff[3];
    int rem[3];
    int sidx[3];
    int kidx[3];
    int order[$];
    int pp;
    int k;
    int acked;
    int granted;
    int cyc;
    int first_ack;
    logic prev_req;
    logic err;
    logic [DW-1:0] rd;
    plan_t pl;
    exp_t  ex;

    cnt[0] = nb; cnt[1] = ni; cnt[2] = nd;
    eff[0] = bm ? nb : 0;
    eff[1] = bm ? 0 : ni;
    eff[2] = bm ? 0 : nd;
    for (int p = 0; p < 3; p++) begin
      rem[p]  = eff[p];
      kidx[p] = 0;
      sidx[p] = 0;
    end

    // Predicted service order
    if (bm) begin
      for (int i = 0; i < eff[0]; i++) order.push_back(P_BOOT);
    end else begin
      while (rem[1] > 0 || rem[2] > 0) begin
        if (rem[1] > 0 && rem[2] > 0) pp = (m_last == P_INST) ? P_DATA : P_INST;
        else                          pp = (rem[1] > 0) ? P_INST : P_DATA;
        m_last = pp;
        rem[pp]--;
        order.push_back(pp);
      end
    end

    // Predicted bus transactions and responses
    foreach (order[i]) begin
      pp = order[i];
      k  = kidx[pp];
      kidx[pp]++;
      pl.port  = pp;
      pl.we    = (pp == P_BOOT) ? 1'b1 : (pp == P_INST) ? 1'b0 : pw[pp][k];
      pl.addr  = pa[pp][k];
      pl.wdata = pd[pp][k];
      pl.delay = pdl[pp][k];
      err = (pl.delay > TB_TIMEOUT);
      if (err) rd = '0;
      else if (pl.we) begin
        model_mem[pl.addr] = pl.wdata;
        rd = pl.wdata;
      end else begin
        rd = model_mem.exists(pl.addr) ? model_mem[pl.addr] : init_word(pl.addr);
      end
      if (pp == P_INST) m_inst_rd = rd;
      if (pp == P_DATA) m_data_rd = rd;
      plan_q.push_back(pl);
      ex.port    = pp;
      ex.err     = err;
      ex.inst_rd = m_inst_rd;
      ex.data_rd = m_data_rd;
      exp_q.push_back(ex);
    end

    boot_mode = bm;
    for (int p = 0; p < 3; p++) if (cnt[p] > 0) apply(p, 0);
    boot_req = (nb > 0);
    inst_req = (ni > 0);
    data_req = (nd > 0);

    acked = 0; granted = 0; cyc = 0; first_ack = -1;
    prev_req = mem_req;
    while (acked < order.size() && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_req && !prev_req) begin
        if (granted < order.size()) scramble(order[granted]);
        granted++;
      end
      prev_req = mem_req;
      if (first_ack < 0 && (boot_ack || inst_ack || data_ack)) first_ack = cyc;
      if (boot_ack && sidx[0] < eff[0]) begin
        sidx[0]++; acked++;
        if (sidx[0] < eff[0]) apply(P_BOOT, sidx[0]); else boot_req = 1'b0;
      end
      if (inst_ack && sidx[1] < eff[1]) begin
        sidx[1]++; acked++;
        if (sidx[1] < eff[1]) apply(P_INST, sidx[1]); else inst_req = 1'b0;
      end
      if (data_ack && sidx[2] < eff[2]) begin
        sidx[2]++; acked++;
        if (sidx[2] < eff[2]) apply(P_DATA, sidx[2]); else data_req = 1'b0;
      end
    end
    check("round_acks", acked, order.size());
    if (order.size() > 0) begin
      pp = order[0];
      check("first_ack_latency", first_ack,
            (pdl[pp][0] > TB_TIMEOUT) ? TB_TIMEOUT + 1 : pdl[pp][0] + 1);
    end

    // Ineligible requests stay up a while and must never be served.
    repeat (4) @(posedge clk);
    #1;
    boot_req = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("round_idle_busy", busy, 0);
    check("round_exp_drain", exp_q.size(), 0);
    check("round_plan_drain", plan_q.size(), 0);
  endtask

  // SRAM controller emulation: checks the bus against the plan, acks on schedule.
  plan_t cur;
  bit    active;
  int    hi;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    active    = 0;
    hi        = 0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (rst) begin
        active = 0;
      end else if (!active) begin
        if (mem_req) begin
          if (plan_q.size() == 0) begin
            check("unexpected_mem_req", plan_q.size(), 1);
            cur = '{port: P_DATA, we: mem_we, addr: mem_addr, wdata: mem_wdata, delay: TB_TIMEOUT + 1};
          end else begin
            cur = plan_q.pop_front();
          end
          active = 1;
          hi     = 1;
          check("mem_we", mem_we, cur.we);
          check("mem_addr", mem_addr, cur.addr);
          if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        end else if ($urandom_range(0, 7) == 0) begin
          mem_ack = 1'b1;  // stray pulse outside BUSY
        end
      end else if (mem_req) begin
        hi++;
        check("mem_addr_hold", mem_addr, cur.addr);
        check("mem_we_hold", mem_we, cur.we);
      end else begin
        check("mem_req_len", hi, (cur.delay > TB_TIMEOUT) ? TB_TIMEOUT : cur.delay);
        active = 0;
      end
      if (active && !rst && mem_req && hi == cur.delay) begin
        mem_ack = 1'b1;
        if (cur.we) begin
          rmem[cur.addr] = cur.wdata;
          mem_rdata      = cur.wdata;
        end else begin
          mem_rdata = rmem.exists(cur.addr) ? rmem[cur.addr] : init_word(cur.addr);
        end
      end
    end
  end

  // Monitor: every ack pulse is matched against the next scoreboard entry.
  initial begin
    exp_t ex;
    int   n;
    int   actp;
    forever begin
      @(negedge clk);
      if (!rst && (boot_ack || inst_ack || data_ack)) begin
        n = int'(boot_ack) + int'(inst_ack) + int'(data_ack);
        check("ack_onehot", n, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", exp_q.size(), 1);
        end else begin
          ex   = exp_q.pop_front();
          actp = boot_ack ? P_BOOT : inst_ack ? P_INST : P_DATA;
          check("ack_port", actp, ex.port);
          check("ack_err", ack_err, ex.err);
          check("inst_rdata", inst_rdata, ex.inst_rd);
          check("data_rdata", data_rdata, ex.data_rd);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    plan_t pl;
    rst = 1'b1;
    boot_mode = 1'b0; boot_req = 1'b0; boot_addr = '0; boot_wdata = '0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {boot_ack, inst_ack, data_ack, ack_err}, 0);
    check("rst_inst_rdata", inst_rdata, 0);
    check("rst_data_rdata", data_rdata, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Boot write with an instruction request that must be ignored
    gen_payloads();
    pa[0][0] = 20'h00010; pd[0][0] = 32'hDEADBEEF; pdl[0][0] = 3;
    run_round(1'b1, 1, 1, 0);

    // Boot-load the word the instruction read will fetch
    gen_payloads();
    pa[0][0] = 20'h00100; pd[0][0] = 32'h12345678; pdl[0][0] = 1;
    run_round(1'b1, 1, 0, 1);

    // Instruction read on the minimum-latency path
    gen_payloads();
    pa[1][0] = 20'h00100; pdl[1][0] = 1;
    run_round(1'b0, 1, 1, 0);

    // Data write then read-back at the same address
    gen_payloads();
    pa[2][0] = 20'h00200; pd[2][0] = 32'hA5A5A5A5; pw[2][0] = 1'b1; pdl[2][0] = 2;
    pa[2][1] = 20'h00200; pw[2][1] = 1'b0; pdl[2][1] = 2;
    run_round(1'b0, 0, 0, 2);

    // Timeout on a data read
    gen_payloads();
    pw[2][0] = 1'b0; pdl[2][0] = TB_TIMEOUT + 1;
    run_round(1'b0, 0, 0, 1);

    // Reset in the second BUSY cycle: no ack, bus request withdrawn
    boot_mode = 1'b0; data_we = 1'b0; data_addr = 20'h00005; data_req = 1'b1;
    pl = '{port: P_DATA, we: 1'b0, addr: 20'h00005, wdata: '0, delay: TB_TIMEOUT + 1};
    plan_q.push_back(pl);
    @(posedge clk);
    #1;
    data_req = 1'b0;
    check("rstbusy_req_c1", mem_req, 1);
    @(posedge clk);
    #1;
    check("rstbusy_req_c2", mem_req, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstbusy_mem_req", mem_req, 0);
    check("rstbusy_busy", busy, 0);
    check("rstbusy_acks", {boot_ack, inst_ack, data_ack}, 0);
    check("rstbusy_data_rdata", data_rdata, 0);
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    // Continuous requests from both ports after reset: inst, data, inst, data
    gen_payloads();
    for (int k = 0; k < 4; k++) begin
      pdl[1][k] = $urandom_range(1, TB_TIMEOUT);
      pdl[2][k] = $urandom_range(1, TB_TIMEOUT);
    end
    run_round(1'b0, 0, 2, 2);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      gen_payloads();
      run_round(1'($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single SRAM controller request port among three requesters: bootloader (write-only), processor instruction fetch (read-only) and processor data port (read/write). Bootloader has exclusive access while `boot_mode` is high; otherwise instruction and data ports are served round-robin. A downstream timeout aborts hung transactions and reports an error. Sits between the processor/bootloader and `sram_fsm`, and replaces the static boot/instruction mux.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 20, word address width
- `TIMEOUT`, 255, max cycles in BUSY awaiting `mem_ack`; 0 disables the timeout
- `clk` in 1: single clock
- `rst` in 1: synchronous reset, active-high
- `boot_mode` in 1: 1 = only the boot port is eligible
- `boot_req` in 1: boot write request, held until `boot_ack`
- `boot_addr` in ADDR_WIDTH: boot write address
- `boot_wdata` in DATA_WIDTH: boot write data
- `boot_ack` out 1: one-cycle completion pulse
- `inst_req` in 1: instruction read request, held until `inst_ack`
- `inst_addr` in ADDR_WIDTH: instruction address
- `inst_ack` out 1: one-cycle completion pulse
- `inst_rdata` out DATA_WIDTH: read data, valid with `inst_ack`
- `data_req` in 1: data request, held until `data_ack`
- `data_we` in 1: 1 = write, 0 = read
- `data_addr` in ADDR_WIDTH: data address
- `data_wdata` in DATA_WIDTH: data write data
- `data_ack` out 1: one-cycle completion pulse
- `data_rdata` out DATA_WIDTH: read data, valid with `data_ack`
- `ack_err` out 1: valid with any ack; 1 = the transaction timed out
- `mem_req` out 1: request to the SRAM controller, held until `mem_ack`
- `mem_we` out 1: write strobe to the controller
- `mem_addr` out ADDR_WIDTH: address to the controller
- `mem_wdata` out DATA_WIDTH: write data to the controller
- `mem_rdata` in DATA_WIDTH: controller read data, valid with `mem_ack`
- `mem_ack` in 1: controller one-cycle completion
- `busy` out 1: high in any state except IDLE

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE, arbitration on the current-cycle requests:
  - `boot_mode`=1: grant boot if `boot_req`; `inst_req` and `data_req` are ignored (never acked).
  - `boot_mode`=0: `boot_req` is ignored. A single requester gets the grant. If both request, grant the port not in `last_grant`.
  - On grant: register the owner, `mem_we` (boot = 1, inst = 0, data = `data_we`), `mem_addr` and `mem_wdata`; clear the timeout counter; go to BUSY.
  - `last_grant` updates only on inst/data grants. Reset value = data, so inst wins the first tie.
- BUSY:
  - `mem_req`=1, with `mem_we`/`mem_addr`/`mem_wdata` held stable.
  - On `mem_ack`: capture `mem_rdata` into the owner's rdata register, set err=0, go to RESP.
  - Else if `TIMEOUT`≠0 and counter == `TIMEOUT`-1: set owner rdata = 0, err=1, go to RESP.
  - Else increment the counter.
- RESP:
  - `mem_req`=0; the owner's ack=1 for exactly this cycle; `ack_err` = err; go to IDLE.
  - Requesters must drop (or re-present) their req by the IDLE cycle.
- Requester payload (addr/we/wdata) is sampled only at grant; later changes are ignored.
- `boot_mode` toggling during BUSY/RESP does not abort; the current transaction completes and the change takes effect at the next IDLE.
- `mem_ack` seen outside BUSY is ignored.
- `inst_rdata`/`data_rdata` hold their last value between acks. Non-owner rdata is unchanged.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `mem_req`, `mem_we`, `busy`, all acks, `ack_err` = 0; `mem_addr`, `mem_wdata`, `inst_rdata`, `data_rdata` = 0; `last_grant` = data; counter = 0.
- Reset in BUSY: `mem_req` is 0 the cycle after the reset edge; no ack is issued for the aborted transaction.
- Request sampled in cycle 0 → `mem_req` high from cycle 1.
- `mem_ack` in cycle k (k≥1) → owner ack in cycle k+1 → IDLE in k+2.
- Minimum req→ack latency: 2 cycles. Minimum spacing between grants: 3 cycles.
- Timeout: with no `mem_ack`, ack with `ack_err`=1 in cycle `TIMEOUT`+1; `mem_req` is high for exactly `TIMEOUT` cycles.

## Test plan
- Boot write: `boot_mode`=1, `boot_req` at addr 0x00010, data 0xDEADBEEF, `mem_ack` 2 cycles after `mem_req` → `mem_we`=1, addr/data match, `boot_ack` pulses once, `ack_err`=0. Simultaneous `inst_req` is never acked.
- Instruction read: `boot_mode`=0, `inst_req` addr 0x00100, `mem_rdata`=0x12345678 with `mem_ack` → `inst_rdata`=0x12345678 with `inst_ack`, 2 cycles after `mem_ack`-free minimum path, `data_rdata` unchanged.
- Round-robin: `inst_req` and `data_req` held high continuously → grant order inst, data, inst, data. Each ack occurs once per transaction.
- Data write then read: `data_we`=1 addr 0x00200 data 0xA5A5A5A5, then `data_we`=0 same addr → controller sees write then read; `data_rdata` = returned `mem_rdata`.
- Timeout: `TIMEOUT`=4, `mem_ack` never asserted → `mem_req` high 4 cycles, then `data_ack`=1, `ack_err`=1, `data_rdata`=0, FSM back to IDLE.
- Reset mid-BUSY: assert `rst` in the second BUSY cycle → `mem_req`=0 and `busy`=0 next cycle, no ack. The first post-reset tie grants inst.
